// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU data memory.
//   size_t     : access size encoding (byte / half / word / reserved)
//   WORD_BYTES : bytes per memory word
//   is_aligned : natural-alignment check of a byte lane for a given size
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  localparam int unsigned WORD_BYTES = 4;

  // Reserved size is never aligned, so it folds into the legality check.
  function automatic logic is_aligned(size_t size, logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lane[0];
      SIZE_WORD: return (lane == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_align.sv
// Combinational lane steering for the data memory.
//   Load side : ld_word_i/ld_size_i/ld_lane_i/ld_zero_ext_i/ld_legal_i
//               -> ld_data_c_o (selected bytes at bit 0, extended; 0 if illegal)
//   Store side: st_size_i/st_lane_i/st_data_i
//               -> st_be_c_o (byte enables), st_wdata_c_o (replicated data)
module lsu_dmem_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lane_i,
  input  logic        ld_zero_ext_i,
  input  logic        ld_legal_i,
  output logic [31:0] ld_data_c_o,
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_c_o,
  output logic [31:0] st_wdata_c_o
);

  logic [31:0] ld_shifted;
  logic        ld_sext;

  // Load: shift addressed lane down to bit 0, then extend.
  always_comb begin
    ld_data_c_o = '0;
    ld_shifted  = ld_word_i >> {ld_lane_i, 3'b000};
    ld_sext     = 1'b0;
    if (ld_legal_i) begin
      case (size_t'(ld_size_i))
        SIZE_BYTE: begin
          ld_sext     = ~ld_zero_ext_i & ld_shifted[7];
          ld_data_c_o = {{24{ld_sext}}, ld_shifted[7:0]};
        end
        SIZE_HALF: begin
          ld_sext     = ~ld_zero_ext_i & ld_shifted[15];
          ld_data_c_o = {{16{ld_sext}}, ld_shifted[15:0]};
        end
        SIZE_WORD: ld_data_c_o = ld_shifted;
        default:   ld_data_c_o = '0;
      endcase
    end
  end

  // Store: replicate data across lanes so the enables alone pick the bytes.
  always_comb begin
    st_be_c_o    = 4'b0000;
    st_wdata_c_o = st_data_i;
    case (size_t'(st_size_i))
      SIZE_BYTE: begin
        st_be_c_o    = 4'b0001 << st_lane_i;
        st_wdata_c_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        st_be_c_o    = 4'b0011 << {st_lane_i[1], 1'b0};
        st_wdata_c_o = {2{st_data_i[15:0]}};
      end
      SIZE_WORD: st_be_c_o = 4'b1111;
      default:   st_be_c_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/lsu_dmem.sv
// LSU data memory: byte-addressed little-endian synchronous SRAM model.
//   clk_i/rst_ni        : clock, async active-low reset
//   stall_i             : pipeline stall; freezes writes, load capture, faults
//   wr_*_i              : store port (addr, right-justified data, en, size)
//   rd_*_i / rd_data_o  : load port, result registered one cycle after request
//   init_*_i            : backdoor word write, wins over a same-word store
//   err_o/err_addr_o/err_is_wr_o/err_clr_i : sticky first-fault capture
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic [31:0]      wr_addr_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_size_i,
  input  logic [31:0]      rd_addr_i,
  input  logic             rd_en_i,
  input  logic [1:0]       rd_size_i,
  input  logic             rd_zero_ext_i,
  output logic [31:0]      rd_data_o,
  input  logic             init_en_i,
  input  logic [IDX_W-1:0] init_idx_i,
  input  logic [31:0]      init_data_i,
  output logic             err_o,
  output logic [31:0]      err_addr_o,
  output logic             err_is_wr_o,
  input  logic             err_clr_i
);

  localparam int unsigned LANE_W  = $clog2(WORD_BYTES);
  localparam int unsigned RANGE_W = IDX_W + LANE_W;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_legal, rd_legal;
  logic             wr_req, rd_req, wr_fire, st_fault, ld_fault;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ld_data;

  logic [31:0]      rd_data_d, rd_data_q;
  logic             err_d, err_q, err_is_wr_d, err_is_wr_q;
  logic [31:0]      err_addr_d, err_addr_q;

  assign wr_idx   = wr_addr_i[RANGE_W-1:LANE_W];
  assign rd_idx   = rd_addr_i[RANGE_W-1:LANE_W];
  assign wr_legal = is_aligned(size_t'(wr_size_i), wr_addr_i[LANE_W-1:0]) &&
                    ((wr_addr_i >> RANGE_W) == 32'd0);
  assign rd_legal = is_aligned(size_t'(rd_size_i), rd_addr_i[LANE_W-1:0]) &&
                    ((rd_addr_i >> RANGE_W) == 32'd0);

  // A store colliding with a backdoor write to the same word is silently dropped.
  assign wr_req   = wr_en_i && !stall_i && !(init_en_i && (wr_idx == init_idx_i));
  assign rd_req   = rd_en_i && !stall_i;
  assign wr_fire  = wr_req && wr_legal;
  assign st_fault = wr_req && !wr_legal;
  assign ld_fault = rd_req && !rd_legal;

  lsu_dmem_align u_align (
    .ld_word_i     (mem_q[rd_idx]),
    .ld_size_i     (rd_size_i),
    .ld_lane_i     (rd_addr_i[LANE_W-1:0]),
    .ld_zero_ext_i (rd_zero_ext_i),
    .ld_legal_i    (rd_legal),
    .ld_data_c_o   (ld_data),
    .st_size_i     (wr_size_i),
    .st_lane_i     (wr_addr_i[LANE_W-1:0]),
    .st_data_i     (wr_data_i),
    .st_be_c_o     (st_be),
    .st_wdata_c_o  (st_wdata)
  );

  // Array: not reset; backdoor write ignores stall.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (st_be[b]) mem_q[wr_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
    if (init_en_i) mem_q[init_idx_i] <= init_data_i;
  end

  // Load result: aligned read-first data; hold on stall, zero when idle.
  always_comb begin
    rd_data_d = rd_data_q;
    if (!stall_i) rd_data_d = rd_en_i ? ld_data : 32'd0;
  end

  // First fault wins; a fault coinciding with clear is still captured.
  always_comb begin
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_is_wr_d = err_is_wr_q;
    if (err_clr_i) begin
      err_d       = 1'b0;
      err_addr_d  = '0;
      err_is_wr_d = 1'b0;
    end
    if ((st_fault || ld_fault) && (!err_q || err_clr_i)) begin
      err_d       = 1'b1;
      err_addr_d  = st_fault ? wr_addr_i : rd_addr_i;
      err_is_wr_d = st_fault;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_is_wr_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_is_wr_q <= err_is_wr_d;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign err_is_wr_o = err_is_wr_q;

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Data memory that sits directly downstream of the LSU lane.
- Consumes the LSU execute-stage store port (wr_*) and load port (rd_*).
- Returns load data one cycle later, aligned and extended, to the LSU writeback stage.
- Byte-addressed, little-endian, synchronous SRAM model with byte-lane writes, stall-aware output hold, and sticky misalignment/out-of-range fault capture.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived, localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall, same signal the LSU pipeline registers see.
- wr_addr  in  32  store byte address.
- wr_data  in  32  store data, right-justified.
- wr_en  in  1  store request.
- wr_size  in  2  store size.
- rd_addr  in  32  load byte address.
- rd_en  in  1  load request.
- rd_size  in  2  load size.
- rd_zero_ext  in  1  1 = zero-extend, 0 = sign-extend.
- rd_data  out  32  load result, valid the cycle after the request.
- init_en  in  1  backdoor word write, used by bench/loader.
- init_idx  in  IDX_W  backdoor word index.
- init_data  in  32  backdoor word data.
- err  out  1  sticky fault flag.
- err_addr  out  32  byte address of the first fault since clear.
- err_is_wr  out  1  first fault was a store.
- err_clr  in  1  clears err, err_addr, err_is_wr.

Behaviour:
- Size encoding: 00 byte, 01 half, 10 word, 11 reserved.
- Word index = addr[IDX_W+1:2]. Byte lane = addr[1:0].
- Reset (rst low, asynchronous): rd_data=0, err=0, err_addr=0, err_is_wr=0, captured load attributes=0. Array contents are not reset.
- Legal request: size != 11, aligned (half needs addr[0]=0, word needs addr[1:0]=00), and addr[31:IDX_W+2]=0.
- Store, on a clock edge with wr_en=1, stall=0, legal:
  - byte writes lane addr[1:0] with wr_data[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0];
  - word writes all lanes.
  - Unaddressed lanes are unchanged.
- Load, on a clock edge with rd_en=1, stall=0:
  - Capture size, zero_ext, lane and legal bit.
  - Read the array read-first.
  - Next cycle rd_data = selected bytes shifted to bit 0, extended to 32 bits per rd_zero_ext.
  - Latency exactly 1.
- Illegal request (rd or wr): no array write. If it is a load, rd_data=0 next cycle.
  - If err=0: set err=1, err_addr=faulting address, err_is_wr=1 for a store.
  - If err=1 already, fault fields are unchanged (first fault wins).
- Load and store in the same cycle: the store is performed and the load returns pre-store contents. Both legality checks apply. If both are illegal, the store is recorded.
- stall=1: no array write, no read capture, rd_data holds its value, fault logic is frozen. Exception: err_clr still clears.
- No request (rd_en=0, stall=0): rd_data <= 0. Writeback of non-loads sees 0.
- init_en=1: writes init_data to init_idx regardless of stall and has priority over a store to the same word that cycle. The store is dropped and no fault is raised.
- err_clr and a new fault in the same cycle: the new fault is captured (set wins).
- Reset mid-operation: the pending load result is lost and rd_data reads 0 after release.

Decomposition:
- lsu_pkg holds:
  - size_t enum with SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD;
  - function is_aligned(size, addr[1:0]);
  - WORD_BYTES constant.
- One sub-module, lsu_dmem_align: combinational.
  - Load side: lane select plus sign/zero extension.
  - Store side: byte-enable and data replication for writes.
  - Instantiated once per direction, or with one load and one store path inside.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word 0x10 next cycle → rd_data=0xDEADBEEF one cycle after rd_en.
- Store byte 0x80 to 0x21 into a word initialised 0x00000000. Load byte 0x21 with zero_ext=0 → 0xFFFFFF80. Load with zero_ext=1 → 0x00000080. Load word 0x20 → 0x00008000.
- Half load from 0x13 → no write, rd_data=0, err=1, err_addr=0x13, err_is_wr=0. Then word store to 0x06 → err fields unchanged. Then err_clr → err=0.
- Issue a load of 0x10 (value 0x11223344), assert stall the following two cycles with new rd_addr 0x20 → rd_data stays 0x11223344 for all stalled cycles. A store presented during stall leaves memory unchanged.
- Store to address 4*DEPTH_WORDS → err=1, err_is_wr=1, array word 0 unchanged.
- Simultaneous store 0xAAAAAAAA and load on 0x30 (old 0x55555555) → rd_data=0x55555555. A subsequent load returns 0xAAAAAAAA. Assert rst low mid-load → rd_data=0 asynchronously.
